f2h_sdram_arbiter: RTL and testbench
====================================

Name: f2h_sdram_arbiter

Overview:
Two-requester Avalon-MM arbiter in front of the HPS FPGA-to-SDRAM port 0 (32-bit data, 32-bit byte address, burst up to 16).
- Requester 0: video frame reader feeding the clocked-video output.
- Requester 1: general DMA/capture master.
- Round-robin grant with burst locking. Read responses are routed back to their issuer through an in-order tag FIFO, so multiple reads can be outstanding.

Parameters:
ADDR_W, 32, address width (byte address)
DATA_W, 32, data width
BURST_W, 5, burstcount width (max burst 16)
MAX_PENDING, 8, tag FIFO depth = max outstanding read bursts (power of 2)

Ports:
clk  in  1  system clock, same domain as hps_f2h_sdram0_clock_clk
reset  in  1  synchronous, active-high
s<n>_address (n=0,1)  in  ADDR_W  requester address
s<n>_burstcount  in  BURST_W  beats in burst
s<n>_read  in  1  read request
s<n>_write  in  1  write request/beat
s<n>_writedata  in  DATA_W  write data
s<n>_byteenable  in  DATA_W/8  byte enables
s<n>_waitrequest  out  1  stall to requester
s<n>_readdata  out  DATA_W  read data (broadcast)
s<n>_readdatavalid  out  1  read beat valid for this requester
m_address  out  ADDR_W  to hps_f2h_sdram0_data_address
m_burstcount  out  BURST_W  to SDRAM port
m_read  out  1  to SDRAM port
m_write  out  1  to SDRAM port
m_writedata  out  DATA_W  to SDRAM port
m_byteenable  out  DATA_W/8  to SDRAM port
m_waitrequest  in  1  from SDRAM port
m_readdata  in  DATA_W  from SDRAM port
m_readdatavalid  in  1  from SDRAM port

Behaviour:
Reset values:
- state=IDLE, last_grant=1 (so s0 wins the first tie), tag FIFO empty, beat counters 0.
- m_read=m_write=0, s<n>_waitrequest=1, s<n>_readdatavalid=0.
- Reset mid-operation aborts any write burst and discards outstanding read tags.
- m_readdatavalid while the FIFO is empty is ignored; no s<n>_readdatavalid is asserted.

FSM states: IDLE, GRANT, WBURST.

IDLE:
- Request r<n> = s<n>_write | (s<n>_read & !fifo_full).
- Single requester: grant it. Both requesting: grant !last_grant.
- Grant is registered; go to GRANT next cycle. Arbitration latency is 1 cycle.

GRANT:
- m_* driven combinationally from the granted requester.
- Granted s<n>_waitrequest = m_waitrequest. Non-granted waitrequest = 1.
- Read accepted (m_read & !m_waitrequest): push {id, burstcount} to the tag FIFO; last_grant<=id; go to IDLE.
- Write beat accepted with burstcount==1: last_grant<=id; go to IDLE.
- Write beat accepted with burstcount>1: latch remaining = burstcount-1; go to WBURST.
- Granted requester drops both read and write before acceptance: go to IDLE (no-op).
- burstcount==0 is treated as 1.

WBURST:
- Locked to the granted id. m_burstcount holds the latched value.
- Each accepted beat decrements remaining.
- Beat taking remaining to 0: last_grant<=id; go to IDLE.
- Other requester is stalled for the whole burst.

Read return path (independent of FSM):
- FIFO head gives id and beat count. Each m_readdatavalid asserts s<id>_readdatavalid in the same cycle (combinational, 0 latency).
- Per-head beat counter increments on each beat; the last beat pops the FIFO.
- Push and pop in the same cycle are allowed; occupancy is unchanged.
- Full (MAX_PENDING entries): reads are not granted and the read requester sees waitrequest=1. Writes are still granted.

Throughput: at most one command per 2 cycles (IDLE+GRANT). Write bursts stream 1 beat/cycle after the first.

Optional Feature:
F2H_ARB_FIXED_PRIO_EN
- Defined: s0 always wins contention in IDLE (video underflow protection); last_grant is unused.
- Undefined: round-robin as above.
- Burst locking and read routing are identical in both builds.

Test Plan:
- Reset, then s0 read burstcount=4 at 0x1000 -> m_read after 1-cycle grant. 4 m_readdatavalid beats appear only on s0_readdatavalid. FIFO empty afterwards.
- s0 and s1 write single beats simultaneously and continuously -> grants alternate s0,s1,s0,s1. With F2H_ARB_FIXED_PRIO_EN: s0 only while it requests.
- s1 write burst 8 with m_waitrequest toggling, s0 read request mid-burst -> s0 stalled until s1's 8th beat is accepted. s0 is then granted next.
- Interleaved reads s0(bc=2), s1(bc=3), s0(bc=1) issued before any data -> 6 return beats routed 2→s0, 3→s1, 1→s0, in order.
- Issue 8 reads with no responses -> 9th read held with waitrequest=1 while a concurrent write is still granted. One completed burst releases the held read.
- Assert reset during a write burst (beat 3 of 8) and during pending reads -> m_write=0 next cycle. Subsequent stray m_readdatavalid produces no s<n>_readdatavalid.

Source files
------------

// File: rtl/f2h_sdram_arbiter_if.sv
// ============================================================================
// Module   : f2h_sdram_arbiter_if
// Function : Avalon-MM bus bundle used on both sides of the F2H SDRAM arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface f2h_sdram_arbiter_if #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int BURST_W = 5
);
  logic [ADDR_W-1:0]   address;
  logic [BURST_W-1:0]  burstcount;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;

  modport master (
    output address, burstcount, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

`default_nettype wire

// File: rtl/f2h_sdram_arbiter.sv
// ============================================================================
// Module   : f2h_sdram_arbiter
// Function : Two-requester round-robin Avalon-MM arbiter with burst locking
//            and in-order read-response routing for HPS F2H SDRAM port 0.
//            Define F2H_ARB_FIXED_PRIO_EN to give s0 fixed priority.
// Revision : 1.0
// ============================================================================
`default_nettype none

module f2h_sdram_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int BURST_W     = 5,
  parameter int MAX_PENDING = 8
) (
  input  wire logic             clk,
  input  wire logic             reset,
  f2h_sdram_arbiter_if.slave    s0,
  f2h_sdram_arbiter_if.slave    s1,
  f2h_sdram_arbiter_if.master   m
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam logic [PTR_W:0] C_FULL = (PTR_W+1)'(MAX_PENDING);
  localparam logic [BURST_W-1:0] C_ONE = BURST_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    WBURST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                grant_q, grant_d;
  logic                last_grant_q, last_grant_d;
  logic [BURST_W-1:0]  remaining_q, remaining_d;
  logic [BURST_W-1:0]  wburst_bc_q, wburst_bc_d;

  logic                fifo_id_q [MAX_PENDING];
  logic                fifo_id_d [MAX_PENDING];
  logic [BURST_W-1:0]  fifo_bc_q [MAX_PENDING];
  logic [BURST_W-1:0]  fifo_bc_d [MAX_PENDING];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [BURST_W-1:0]  beat_cnt_q, beat_cnt_d;

  logic [ADDR_W-1:0]   sel_address;
  logic [BURST_W-1:0]  sel_bc, sel_bc_norm, m_bc;
  logic                sel_read, sel_write;
  logic [DATA_W-1:0]   sel_writedata;
  logic [DATA_W/8-1:0] sel_byteenable;
  logic                fifo_full, fifo_empty, req0, req1, tie_pick;
  logic                m_read_o, m_write_o, grant_wait, push, pop, rd_beat;
  logic                head_id;
  logic [BURST_W-1:0]  head_bc;

  assign sel_address    = grant_q ? s1.address    : s0.address;
  assign sel_bc         = grant_q ? s1.burstcount : s0.burstcount;
  assign sel_read       = grant_q ? s1.read       : s0.read;
  assign sel_write      = grant_q ? s1.write      : s0.write;
  assign sel_writedata  = grant_q ? s1.writedata  : s0.writedata;
  assign sel_byteenable = grant_q ? s1.byteenable : s0.byteenable;
  assign sel_bc_norm    = (sel_bc == '0) ? C_ONE : sel_bc;

  assign fifo_full  = (count_q == C_FULL);
  assign fifo_empty = (count_q == '0);
  assign req0 = s0.write | (s0.read & ~fifo_full);
  assign req1 = s1.write | (s1.read & ~fifo_full);

`ifdef F2H_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
`else
  assign tie_pick = ~last_grant_q;
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    wburst_bc_d  = wburst_bc_q;
    m_read_o     = 1'b0;
    m_write_o    = 1'b0;
    m_bc         = sel_bc;
    grant_wait   = 1'b1;
    push         = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = GRANT;
          grant_d = (req0 & req1) ? tie_pick : req1;
        end
      end
      GRANT: begin
        // Writes take precedence if a requester illegally asserts both
        m_write_o  = sel_write;
        m_read_o   = sel_read & ~sel_write & ~fifo_full;
        grant_wait = ~(m_read_o | m_write_o) | m.waitrequest;
        if (m_read_o & ~m.waitrequest) begin
          push         = 1'b1;
          last_grant_d = grant_q;
          state_d      = IDLE;
        end else if (m_write_o & ~m.waitrequest) begin
          if (sel_bc_norm == C_ONE) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            remaining_d = sel_bc_norm - C_ONE;
            wburst_bc_d = sel_bc_norm;
            state_d     = WBURST;
          end
        end else if (~sel_read & ~sel_write) begin
          state_d = IDLE;
        end
      end
      WBURST: begin
        m_write_o  = sel_write;
        m_bc       = wburst_bc_q;
        grant_wait = ~sel_write | m.waitrequest;
        if (sel_write & ~m.waitrequest) begin
          remaining_d = remaining_q - C_ONE;
          if (remaining_q == C_ONE) begin
            last_grant_d = grant_q;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read return: head of the tag FIFO names the owner of every returning beat
  assign head_id = fifo_id_q[rd_ptr_q];
  assign head_bc = fifo_bc_q[rd_ptr_q];
  assign rd_beat = m.readdatavalid & ~fifo_empty;
  assign pop     = rd_beat & ((beat_cnt_q + C_ONE) == head_bc);

  always_comb begin
    fifo_id_d  = fifo_id_q;
    fifo_bc_d  = fifo_bc_q;
    beat_cnt_d = beat_cnt_q;
    if (push) begin
      fifo_id_d[wr_ptr_q] = grant_q;
      fifo_bc_d[wr_ptr_q] = sel_bc_norm;
    end
    if (rd_beat) beat_cnt_d = pop ? '0 : beat_cnt_q + C_ONE;
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop};
    count_d  = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      remaining_q  <= '0;
      wburst_bc_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      wburst_bc_q  <= wburst_bc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_cnt_q   <= beat_cnt_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q is non-zero
  always_ff @(posedge clk) begin
    fifo_id_q <= fifo_id_d;
    fifo_bc_q <= fifo_bc_d;
  end

  assign m.address    = sel_address;
  assign m.burstcount = m_bc;
  assign m.read       = m_read_o;
  assign m.write      = m_write_o;
  assign m.writedata  = sel_writedata;
  assign m.byteenable = sel_byteenable;

  assign s0.waitrequest   = grant_q ? 1'b1 : grant_wait;
  assign s1.waitrequest   = grant_q ? grant_wait : 1'b1;
  assign s0.readdata      = m.readdata;
  assign s1.readdata      = m.readdata;
  assign s0.readdatavalid = rd_beat & ~head_id;
  assign s1.readdatavalid = rd_beat & head_id;

endmodule

`default_nettype wire

// File: tb/tb_f2h_sdram_arbiter.sv
// ============================================================================
// Module   : tb_f2h_sdram_arbiter
// Function : Directed self-checking bench for f2h_sdram_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_f2h_sdram_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  f2h_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(5)) s0_if ();
  f2h_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(5)) s1_if ();
  f2h_sdram_arbiter_if #(.ADDR_W(32), .DATA_W(32), .BURST_W(5)) m_if ();

  f2h_sdram_arbiter #(
    .ADDR_W(32), .DATA_W(32), .BURST_W(5), .MAX_PENDING(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .s0    (s0_if),
    .s1    (s1_if),
    .m     (m_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    s0_if.address = '0; s0_if.burstcount = 5'd1; s0_if.read = 1'b0; s0_if.write = 1'b0;
    s0_if.writedata = '0; s0_if.byteenable = 4'hF;
    s1_if.address = '0; s1_if.burstcount = 5'd1; s1_if.read = 1'b0; s1_if.write = 1'b0;
    s1_if.writedata = '0; s1_if.byteenable = 4'hF;
    m_if.waitrequest = 1'b0; m_if.readdata = '0; m_if.readdatavalid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic issue_read(input bit id, input logic [31:0] addr, input logic [4:0] bc);
    bit done;
    done = 1'b0;
    if (id) begin s1_if.read = 1'b1; s1_if.address = addr; s1_if.burstcount = bc; end
    else    begin s0_if.read = 1'b1; s0_if.address = addr; s0_if.burstcount = bc; end
    for (int c = 0; c < 20 && !done; c++) begin
      #1;
      if (id ? !s1_if.waitrequest : !s0_if.waitrequest) done = 1'b1;
      @(negedge clk);
    end
    if (id) s1_if.read = 1'b0; else s0_if.read = 1'b0;
    chk("rd_accept", 32'(done), 32'd1);
  endtask

  initial begin
    int win [8];
    int n, beats, stall_bad, dat_bad, held_bad, wgrant, exp_w;
    bit acc, got;
    logic [5:0] exp_ids;
    total = 0;
    bad   = 0;

    // Reset state, with a stray response beat that must be ignored
    reset = 1'b1;
    idle_inputs();
    m_if.readdatavalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_m_read", 32'(m_if.read), 32'd0);
    chk("rst_m_write", 32'(m_if.write), 32'd0);
    chk("rst_s0_wait", 32'(s0_if.waitrequest), 32'd1);
    chk("rst_s1_wait", 32'(s1_if.waitrequest), 32'd1);
    chk("rst_rdv", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), 32'd0);

    // Single s0 read burst of 4
    @(negedge clk);
    reset = 1'b0;
    m_if.readdatavalid = 1'b0;
    s0_if.read = 1'b1; s0_if.address = 32'h1000; s0_if.burstcount = 5'd4;
    #1;
    chk("t1_idle_wait", 32'(s0_if.waitrequest), 32'd1);
    chk("t1_idle_mread", 32'(m_if.read), 32'd0);
    @(negedge clk);
    #1;
    chk("t1_m_read", 32'(m_if.read), 32'd1);
    chk("t1_m_addr", m_if.address, 32'h1000);
    chk("t1_m_bc", 32'(m_if.burstcount), 32'd4);
    chk("t1_s0_wait", 32'(s0_if.waitrequest), 32'd0);
    @(negedge clk);
    s0_if.read = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_if.readdatavalid = 1'b1;
      m_if.readdata = 32'hD0 + i;
      #1;
      chk("t1_route", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), 32'd1);
      chk("t1_rdata", s0_if.readdata, 32'hD0 + i);
    end
    @(negedge clk);
    #1;
    chk("t1_empty", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), 32'd0);
    @(negedge clk);
    m_if.readdatavalid = 1'b0;

    // Continuous single-beat writes from both requesters
    do_reset();
    s0_if.write = 1'b1; s0_if.writedata = 32'h50; s0_if.address = 32'h10;
    s1_if.write = 1'b1; s1_if.writedata = 32'h51; s1_if.address = 32'h20;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!s0_if.waitrequest && m_if.write && m_if.writedata == 32'h50) begin win[n] = 0; n++; end
      else if (!s1_if.waitrequest && m_if.write && m_if.writedata == 32'h51) begin win[n] = 1; n++; end
      @(negedge clk);
    end
    chk("t2_ngrants", 32'(n), 32'd4);
    for (int k = 0; k < 4 && k < n; k++) begin
`ifdef F2H_ARB_FIXED_PRIO_EN
      exp_w = 0;
`else
      exp_w = k % 2;
`endif
      chk("t2_winner", 32'(win[k]), 32'(exp_w));
    end
    s0_if.write = 1'b0;
    s1_if.write = 1'b0;

    // s1 burst of 8 with toggling waitrequest; s0 read arrives mid-burst
    do_reset();
    s1_if.write = 1'b1; s1_if.burstcount = 5'd8; s1_if.address = 32'h2000;
    beats = 0; stall_bad = 0; dat_bad = 0;
    for (int c = 0; c < 60 && beats < 8; c++) begin
      s1_if.writedata = 32'hA0 + beats;
      m_if.waitrequest = c[0];
      if (c == 3) begin s0_if.read = 1'b1; s0_if.address = 32'h3000; s0_if.burstcount = 5'd1; end
      #1;
      if (s0_if.read && !s0_if.waitrequest) stall_bad++;
      if (m_if.write && !m_if.waitrequest) begin
        if (s1_if.waitrequest) dat_bad++;
        if (m_if.writedata != 32'hA0 + beats) dat_bad++;
        if (m_if.burstcount != 5'd8) dat_bad++;
        beats++;
      end
      @(negedge clk);
    end
    chk("t3_beats", 32'(beats), 32'd8);
    chk("t3_s0_stall", 32'(stall_bad), 32'd0);
    chk("t3_beat_data", 32'(dat_bad), 32'd0);
    s1_if.write = 1'b0;
    m_if.waitrequest = 1'b0;
    #1;
    chk("t3_idle_s0_wait", 32'(s0_if.waitrequest), 32'd1);
    chk("t3_idle_mwrite", 32'(m_if.write), 32'd0);
    @(negedge clk);
    #1;
    chk("t3_s0_grant", 32'(s0_if.waitrequest), 32'd0);
    chk("t3_m_read", 32'(m_if.read), 32'd1);
    chk("t3_m_addr", m_if.address, 32'h3000);
    @(negedge clk);
    s0_if.read = 1'b0;

    // Interleaved outstanding reads routed in issue order
    do_reset();
    issue_read(1'b0, 32'h100, 5'd2);
    issue_read(1'b1, 32'h200, 5'd3);
    issue_read(1'b0, 32'h300, 5'd1);
    exp_ids = 6'b011100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      m_if.readdatavalid = 1'b1;
      m_if.readdata = 32'hE0 + i;
      #1;
      chk("t4_route", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), exp_ids[i] ? 32'd2 : 32'd1);
    end
    @(negedge clk);
    #1;
    chk("t4_empty", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), 32'd0);
    @(negedge clk);
    m_if.readdatavalid = 1'b0;

    // Fill the tag FIFO; ninth read held while a write still gets through
    do_reset();
    for (int k = 0; k < 8; k++) issue_read(1'b0, 32'h400 + 32'(k) * 64, 5'd1);
    s0_if.read = 1'b1; s0_if.address = 32'h800; s0_if.burstcount = 5'd1;
    s1_if.write = 1'b1; s1_if.address = 32'h900; s1_if.writedata = 32'h99; s1_if.burstcount = 5'd1;
    held_bad = 0; wgrant = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (!s0_if.waitrequest || m_if.read) held_bad++;
      acc = s1_if.write && !s1_if.waitrequest && m_if.write;
      if (acc) wgrant++;
      @(negedge clk);
      if (acc) s1_if.write = 1'b0;
    end
    chk("t5_held", 32'(held_bad), 32'd0);
    chk("t5_wgrant", 32'(wgrant), 32'd1);
    m_if.readdatavalid = 1'b1;
    #1;
    chk("t5_rdv", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), 32'd1);
    @(negedge clk);
    m_if.readdatavalid = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      #1;
      if (!s0_if.waitrequest && m_if.read && m_if.address == 32'h800) got = 1'b1;
      @(negedge clk);
    end
    chk("t5_release", 32'(got), 32'd1);
    s0_if.read = 1'b0;

    // Reset in the middle of a write burst with reads outstanding
    do_reset();
    issue_read(1'b1, 32'hA00, 5'd2);
    issue_read(1'b1, 32'hA40, 5'd2);
    s0_if.write = 1'b1; s0_if.address = 32'hB00; s0_if.burstcount = 5'd8;
    beats = 0;
    for (int c = 0; c < 20 && beats < 3; c++) begin
      s0_if.writedata = 32'hB0 + beats;
      #1;
      if (m_if.write && !s0_if.waitrequest) beats++;
      @(negedge clk);
    end
    chk("t6_beats", 32'(beats), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_m_write_rst", 32'(m_if.write), 32'd0);
    chk("t6_s0_wait_rst", 32'(s0_if.waitrequest), 32'd1);
    reset = 1'b0;
    s0_if.write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      m_if.readdatavalid = 1'b1;
      #1;
      chk("t6_stray", 32'({s1_if.readdatavalid, s0_if.readdatavalid}), 32'd0);
    end
    @(negedge clk);
    m_if.readdatavalid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
